cur_mem_writer: RTL and testbench
=================================

Name: cur_mem_writer

Overview:
- Byte-to-word packer and writer that loads a current-frame pixel stream into the byte-addressed current-frame memory.
- Accepts 8-bit pixels over a valid/ready stream and packs them little-endian into 32-bit words: byte at address A+k goes to lane k, bits [8k+7:8k].
- Issues word writes with byte enables.
- Write-side counterpart of the 32-bit little-endian current-frame read path. Sits between the frame loader/DMA and the current-frame memory.

Parameters:
- MEM_BYTES, 8300001, memory depth in bytes; highest legal byte address is MEM_BYTES-1.
- LEN_W, 32, width of frame_len and the internal byte counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a frame load; sampled only in IDLE
- base_addr  input  32  first byte address; must be a multiple of 4; sampled on start
- frame_len  input  LEN_W  number of bytes to write; sampled on start
- pix_valid  input  1  pixel byte valid
- pix_data  input  8  pixel byte
- pix_ready  output  1  writer accepts pix_data this cycle
- wr_en  output  1  write request to memory
- wr_addr  output  32  word-aligned byte address of the write
- wr_data  output  32  packed word, lane k = byte at wr_addr+k
- wr_be  output  4  byte enables, bit k enables lane k
- wr_ready  input  1  memory accepts the write this cycle
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at end of load
- err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_be=0, busy=0, done=0, err=0. FSM goes to IDLE; byte counter and lane index clear.
- Reset mid-load abandons any partial word with no further write. A write held on wr_en is dropped.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - On start, latch base_addr and frame_len, clear the counter and lane index, and clear wr_data/wr_be.
  - If base_addr[1:0]!=0, or base_addr+frame_len > MEM_BYTES (computed 33-bit, no wrap): pulse err next cycle, stay IDLE, no writes.
  - Else if frame_len==0: go to DONE.
  - Else: go to FILL.
- FILL:
  - pix_ready=1. On pix_valid&&pix_ready, write pix_data to lane[lane_idx], set wr_be[lane_idx], increment lane_idx (2-bit) and the byte counter.
  - Go to WRITE when the accepted byte fills lane 3, or when the counter reaches frame_len.
  - No byte is accepted in the cycle the transition is taken beyond that final byte.
- WRITE:
  - pix_ready=0 and wr_en=1. wr_addr, wr_data and wr_be are held stable until wr_ready.
  - On wr_en&&wr_ready: wr_addr += 4, clear wr_data/wr_be, and lane_idx returns to 0.
  - Then go to DONE if counter==frame_len, else FILL.
  - wr_ready may already be high on the first WRITE cycle, giving a one-cycle write.
- DONE: done=1 for exactly one cycle, busy=0, next state IDLE.
- Final partial word: unused lanes are 0 and their wr_be bits are 0. Example: a final 1 byte gives wr_be=4'b0001.
- Throughput: at most 4 bytes per 5 cycles with wr_ready tied high (4 FILL + 1 WRITE).
- busy: 1 in FILL and WRITE, 0 otherwise. start outside IDLE is ignored, with no err.
- pix_valid outside FILL is ignored; the byte is not consumed because pix_ready=0.
- Counter width is LEN_W; no wrap is possible because length is range-checked at start.

Test Plan:
- Aligned load: base_addr=0x100, frame_len=8, bytes 0x11..0x88, wr_ready=1 → writes (0x100, 0x44332211, 4'hF) and (0x104, 0x88776655, 4'hF); done pulses once.
- Partial tail: base_addr=0, frame_len=5, bytes 01..05 → (0x0, 0x04030201, F) then (0x4, 0x00000005, 4'b0001); done.
- Backpressure: hold wr_ready=0 for 3 cycles during the first write → wr_addr/wr_data/wr_be stay constant, pix_ready=0 throughout, and the single write completes when wr_ready rises. Also deassert pix_valid mid-word → no byte is lost or duplicated.
- Rejects: base_addr=0x2 → err pulse, no wr_en. base_addr=MEM_BYTES-4 with frame_len=8 → err. frame_len=0 → done next cycle, no writes, no err.
- Reset mid-load: assert rst after 2 of 4 bytes → all outputs return to reset values next cycle, no write issued. A following start with frame_len=4 writes correctly from the new base.
- start while busy → ignored; the original load's addresses and data are unaffected.

Source files
------------

// File: rtl/cur_mem_writer_if.sv
// Stream-in / memory-write-out bundle for the current-frame writer.
// master = loader/memory side, slave = the writer itself.
interface cur_mem_writer_if #(
  parameter int LEN_W = 32
);
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] frame_len;
  logic             pix_valid;
  logic [7:0]       pix_data;
  logic             pix_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             wr_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, base_addr, frame_len, pix_valid, pix_data, wr_ready,
    input  pix_ready, wr_en, wr_addr, wr_data, wr_be, busy, done, err
  );

  modport slave (
    input  start, base_addr, frame_len, pix_valid, pix_data, wr_ready,
    output pix_ready, wr_en, wr_addr, wr_data, wr_be, busy, done, err
  );
endinterface

// File: rtl/cur_mem_writer.sv
// Packs an 8-bit pixel stream little-endian into 32-bit words and writes
// them with byte enables into the byte-addressed current-frame memory.
module cur_mem_writer #(
  parameter int unsigned MEM_BYTES = 8300001,
  parameter int          LEN_W     = 32
) (
  input  logic clk,
  input  logic rst,
  cur_mem_writer_if.slave bus
);

  localparam int SUM_W = ((LEN_W > 32) ? LEN_W : 32) + 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q,  addr_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       lane_q,  lane_d;
  logic [31:0]      data_q,  data_d;
  logic [3:0]       be_q,    be_d;
  logic             err_q,   err_d;

  // Widened sum so a range that runs past the end of memory cannot wrap.
  logic range_bad;
  assign range_bad = (SUM_W'(bus.base_addr) + SUM_W'(bus.frame_len)) > SUM_W'(MEM_BYTES);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    data_d  = data_q;
    be_d    = be_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        addr_d = bus.base_addr;
        len_d  = bus.frame_len;
        cnt_d  = '0;
        lane_d = 2'd0;
        data_d = '0;
        be_d   = '0;
        if (bus.base_addr[1:0] != 2'd0 || range_bad) err_d   = 1'b1;
        else if (bus.frame_len == '0)                state_d = DONE;
        else                                         state_d = FILL;
      end
      FILL: if (bus.pix_valid) begin
        for (int k = 0; k < 4; k++) begin
          if (lane_q == 2'(k)) begin
            data_d[8*k +: 8] = bus.pix_data;
            be_d[k]          = 1'b1;
          end
        end
        lane_d = lane_q + 2'd1;
        cnt_d  = cnt_q + LEN_W'(1);
        if (lane_q == 2'd3 || cnt_d == len_q) state_d = WRITE;
      end
      WRITE: if (bus.wr_ready) begin
        addr_d  = addr_q + 32'd4;
        data_d  = '0;
        be_d    = '0;
        lane_d  = 2'd0;
        state_d = (cnt_q == len_q) ? DONE : FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset discards any partially packed word; a pending write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= 2'd0;
      data_q  <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  assign bus.pix_ready = (state_q == FILL);
  assign bus.wr_en     = (state_q == WRITE);
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.wr_be     = be_q;
  assign bus.busy      = (state_q == FILL) || (state_q == WRITE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cur_mem_writer.sv
// Randomized bench for cur_mem_writer: expected writes are derived from the
// byte list of each load and checked on every cycle wr_en is high.
module tb_cur_mem_writer;
  localparam int unsigned MEM_BYTES = 8300001;
  localparam int          LEN_W     = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cur_mem_writer_if #(.LEN_W(LEN_W)) bus ();
  cur_mem_writer #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got_q[$];
  logic [7:0] bytes_q[$];
  int vec = 0, miss = 0, done_seen = 0, err_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Checks every write-cycle against the head of the expected-write list.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          chk("wr_addr", bus.wr_addr, exp_q[0].addr);
          chk("wr_data", bus.wr_data, exp_q[0].data);
          chk("wr_be",   {28'd0, bus.wr_be}, {28'd0, exp_q[0].be});
        end
        chk("pix_ready_in_write", {31'd0, bus.pix_ready}, 32'd0);
        chk("busy_in_write", {31'd0, bus.busy}, 32'd1);
        if (bus.wr_ready) begin
          got_q.push_back('{bus.wr_addr, bus.wr_data, bus.wr_be});
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      if (bus.done) begin
        done_seen++;
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
      if (bus.err) err_seen++;
    end
  end

  // Expected writes: word i holds bytes 4i..4i+3, missing tail lanes are 0.
  task automatic build_expected(input logic [31:0] base);
    int n;
    wr_t w;
    n = bytes_q.size();
    exp_q.delete();
    for (int i = 0; i < n; i += 4) begin
      w.addr = base + 32'(i);
      w.data = '0;
      w.be   = '0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < n) begin
          w.data[8*k +: 8] = bytes_q[i+k];
          w.be[k]          = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_bytes(input int n, input int seq);
    bytes_q.delete();
    for (int i = 0; i < n; i++)
      bytes_q.push_back(seq != 0 ? 8'(seq * (i + 1)) : 8'($urandom));
  endtask

  // rmode: 0 wr_ready high, 1 random, 2 stall first write 3 cycles.
  task automatic run_load(input logic [31:0] base, input int vpct, input int rmode, input bit restart);
    int  d0, e0, idx, cyc, stall, len;
    bit  acc;
    len = bytes_q.size();
    build_expected(base);
    got_q.delete();
    d0 = done_seen; e0 = err_seen; idx = 0; cyc = 0; stall = 0;
    bus.start = 1'b1; bus.base_addr = base; bus.frame_len = LEN_W'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (done_seen == d0 && cyc < 3000) begin
      bus.pix_valid = (idx < len) && ($urandom_range(99) < vpct);
      bus.pix_data  = (idx < len) ? bytes_q[idx] : 8'($urandom);
      case (rmode)
        0: bus.wr_ready = 1'b1;
        1: bus.wr_ready = 1'($urandom_range(1));
        default: begin
          if (bus.wr_en && got_q.size() == 0 && stall < 3) begin
            bus.wr_ready = 1'b0;
            stall++;
          end else bus.wr_ready = 1'b1;
        end
      endcase
      if (restart && cyc == 2) begin
        bus.start = 1'b1; bus.base_addr = 32'h8; bus.frame_len = LEN_W'(4);
      end else bus.start = 1'b0;
      @(negedge clk);
      acc = bus.pix_valid && bus.pix_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("load_timeout",   {31'd0, cyc < 3000}, 32'd1);
    chk("bytes_consumed", 32'(idx), 32'(len));
    chk("exp_drained",    32'(exp_q.size()), 32'd0);
    chk("done_count",     32'(done_seen - d0), 32'd1);
    chk("no_err",         32'(err_seen - e0), 32'd0);
    chk("idle_busy",      {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic try_start_no_load(input logic [31:0] base, input logic [31:0] len, input bit want_err);
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    exp_q.delete();
    bus.start = 1'b1; bus.base_addr = base; bus.frame_len = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("err_next_cycle",  {31'd0, bus.err},  {31'd0, want_err});
    chk("done_next_cycle", {31'd0, bus.done}, {31'd0, !want_err});
    chk("busy_after_start", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_count",  32'(err_seen - e0),  {31'd0, want_err});
    chk("done_count", 32'(done_seen - d0), {31'd0, !want_err});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, {31'd0, bus.pix_ready}, 32'd0);
    chk({tag, "_wr_en"},     {31'd0, bus.wr_en},     32'd0);
    chk({tag, "_wr_addr"},   bus.wr_addr,            32'd0);
    chk({tag, "_wr_data"},   bus.wr_data,            32'd0);
    chk({tag, "_wr_be"},     {28'd0, bus.wr_be},     32'd0);
    chk({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
    chk({tag, "_done"},      {31'd0, bus.done},      32'd0);
    chk({tag, "_err"},       {31'd0, bus.err},       32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.frame_len = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Aligned 8-byte load, literal expectations.
    fill_bytes(8, 8'h11);
    run_load(32'h100, 100, 0, 1'b0);
    chk("t1_nwrites", 32'(got_q.size()), 32'd2);
    chk("t1_w0_addr", got_q[0].addr, 32'h100);
    chk("t1_w0_data", got_q[0].data, 32'h44332211);
    chk("t1_w0_be",   {28'd0, got_q[0].be}, 32'hF);
    chk("t1_w1_addr", got_q[1].addr, 32'h104);
    chk("t1_w1_data", got_q[1].data, 32'h88776655);

    // Partial tail word.
    fill_bytes(5, 1);
    run_load(32'h0, 100, 0, 1'b0);
    chk("t2_nwrites", 32'(got_q.size()), 32'd2);
    chk("t2_w0_data", got_q[0].data, 32'h04030201);
    chk("t2_w1_addr", got_q[1].addr, 32'h4);
    chk("t2_w1_data", got_q[1].data, 32'h00000005);
    chk("t2_w1_be",   {28'd0, got_q[1].be}, 32'h1);

    // Backpressure on first write plus gappy pixel stream.
    fill_bytes(8, 0);
    run_load(32'h40, 50, 2, 1'b0);

    // Rejects, zero length, and the very last legal byte.
    try_start_no_load(32'h2, 32'd4, 1'b1);
    try_start_no_load(MEM_BYTES - 4, 32'd8, 1'b1);
    try_start_no_load(32'd8300000, 32'd2, 1'b1);
    try_start_no_load(32'h10, 32'd0, 1'b0);
    fill_bytes(1, 0);
    run_load(32'd8300000, 100, 0, 1'b0);
    chk("last_byte_be", {28'd0, got_q[0].be}, 32'h1);

    // Reset after two of four bytes: no write, then a clean reload.
    exp_q.delete();
    bus.start = 1'b1; bus.base_addr = 32'h200; bus.frame_len = LEN_W'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b1; bus.pix_data = 8'hA1;
    @(posedge clk); #1;
    bus.pix_data = 8'hA2;
    @(posedge clk); #1;
    rst = 1'b1; bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    fill_bytes(4, 3);
    run_load(32'h300, 100, 0, 1'b0);
    chk("post_rst_addr", got_q[0].addr, 32'h300);
    chk("post_rst_data", got_q[0].data, 32'h0C090603);

    // start while busy is ignored.
    fill_bytes(12, 0);
    run_load(32'h500, 70, 1, 1'b1);

    // Random loads.
    for (int t = 0; t < 12; t++) begin
      fill_bytes($urandom_range(40, 1), 0);
      run_load(32'($urandom_range(32'h10_0000)) & ~32'h3, $urandom_range(100, 30), 1, 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
